// File: rtl/fp_mult_requester_if.sv
// rtl/fp_mult_requester_if.sv - operand stream, multiplier handshake and result stream bundle
interface fp_mult_requester_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_op_a;
    logic [W-1:0] in_op_b;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         beg_FSM;
    logic         rst_FSM;
    logic         mult_abort;
    logic         mult_ready;
    logic [W-1:0] mult_result;
    logic         mult_ov;
    logic         mult_un;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_ov;
    logic         out_un;
    logic         out_timeout;
    logic         busy;

    modport master (
        input  in_valid, in_op_a, in_op_b,
        input  mult_ready, mult_result, mult_ov, mult_un,
        input  out_ready,
        output in_ready, op_a, op_b, beg_FSM, rst_FSM, mult_abort,
        output out_valid, out_result, out_ov, out_un, out_timeout, busy
    );

    modport slave (
        output in_valid, in_op_a, in_op_b,
        output mult_ready, mult_result, mult_ov, mult_un,
        output out_ready,
        input  in_ready, op_a, op_b, beg_FSM, rst_FSM, mult_abort,
        input  out_valid, out_result, out_ov, out_un, out_timeout, busy
    );
endinterface

// File: rtl/fp_mult_requester.sv
// rtl/fp_mult_requester.sv - initiator for the multiplier begin/ready/acknowledge handshake
module fp_mult_requester #(
    parameter int W       = 32,
    parameter int TIMEOUT = 63,
    parameter int ACK_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_mult_requester_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        ACK   = 3'd3,
        HOLD  = 3'd4,
        ABORT = 3'd5
    } state_t;

    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);
    localparam logic [7:0] ACK_L     = 8'(ACK_MAX);
    localparam logic [7:0] TIMER_MAX = 8'hFF;

    state_t       state;
    state_t       state_nxt;
    logic [7:0]   timer;
    logic [7:0]   timer_nxt;
    logic         load_ops;
    logic         capture;
    logic         do_abort;

    logic [W-1:0] op_a_q;
    logic [W-1:0] op_b_q;
    logic [W-1:0] result_q;
    logic         ov_q;
    logic         un_q;
    logic         timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            timer <= 8'd0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        load_ops  = 1'b0;
        capture   = 1'b0;
        do_abort  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    load_ops  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                timer_nxt = 8'd0;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.mult_ready) begin
                    capture   = 1'b1;
                    timer_nxt = 8'd0;
                    state_nxt = ACK;
                end else if (timer == TIMEOUT_L) begin
                    state_nxt = ABORT;
                end else if (timer != TIMER_MAX) begin
                    timer_nxt = timer + 8'd1;
                end
            end
            ACK: begin
                // Ready must fall in answer to rst_FSM; a multiplier that keeps it up is aborted.
                if (!bus.mult_ready) begin
                    state_nxt = HOLD;
                end else if (timer == ACK_L) begin
                    state_nxt = ABORT;
                end else if (timer != TIMER_MAX) begin
                    timer_nxt = timer + 8'd1;
                end
            end
            ABORT: begin
                do_abort  = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q    <= '0;
            op_b_q    <= '0;
            result_q  <= '0;
            ov_q      <= 1'b0;
            un_q      <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (load_ops) begin
                op_a_q    <= bus.in_op_a;
                op_b_q    <= bus.in_op_b;
                ov_q      <= 1'b0;
                un_q      <= 1'b0;
                timeout_q <= 1'b0;
            end
            if (capture) begin
                result_q <= bus.mult_result;
                ov_q     <= bus.mult_ov;
                un_q     <= bus.mult_un;
            end
            // Flags captured before an ACK-side abort are deliberately left intact.
            if (do_abort) begin
                result_q  <= '0;
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.beg_FSM     = (state == ISSUE);
    assign bus.rst_FSM     = (state == ACK);
    assign bus.mult_abort  = (state == ABORT);
    assign bus.out_valid   = (state == HOLD);
    assign bus.busy        = (state != IDLE);
    assign bus.op_a        = op_a_q;
    assign bus.op_b        = op_b_q;
    assign bus.out_result  = result_q;
    assign bus.out_ov      = ov_q;
    assign bus.out_un      = un_q;
    assign bus.out_timeout = timeout_q;
endmodule

// File: tb/tb_fp_mult_requester.sv
// tb/tb_fp_mult_requester.sv - self-checking bench with behavioural multiplier and reference timing
module tb_fp_mult_requester;
    localparam int W       = 32;
    localparam int TIMEOUT = 63;
    localparam int ACK_MAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_mult_requester_if #(.W(W)) bus ();

    fp_mult_requester #(.W(W), .TIMEOUT(TIMEOUT), .ACK_MAX(ACK_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int m_lat       = 1;
    bit m_compliant = 1'b1;
    bit m_pending   = 1'b0;
    int m_ready_at  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; afterwards the multiplier model reacts to what the DUT drove during that cycle.
    task automatic tick();
        logic saw_beg, saw_ack, saw_abort;
        saw_beg   = bus.beg_FSM;
        saw_ack   = bus.rst_FSM;
        saw_abort = bus.mult_abort;
        @(posedge clk);
        #1;
        cyc++;
        if (saw_abort || rst) begin
            m_pending      = 1'b0;
            bus.mult_ready = 1'b0;
        end else begin
            if (saw_ack && m_compliant) bus.mult_ready = 1'b0;
            if (saw_beg) begin
                m_pending  = 1'b1;
                m_ready_at = cyc - 1 + m_lat;
            end
            if (m_pending && cyc == m_ready_at) begin
                bus.mult_ready = 1'b1;
                m_pending      = 1'b0;
            end
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                          input logic ov, input logic un, input int lat, input bit compliant,
                          input int hold);
        bit          ok_path, exp_to;
        int          exp_lat, exp_acks, beg_cnt, ack_cnt, abort_cnt, beg_cyc, t, op_bad;
        logic [31:0] exp_res, held;
        logic        exp_ov, exp_un;

        // Reference: ready is caught only inside the TIMEOUT+1 cycle WAIT window.
        ok_path  = (lat >= 1) && (lat <= TIMEOUT + 1);
        exp_to   = !ok_path || !compliant;
        exp_res  = exp_to ? 32'h0 : res;
        exp_ov   = ok_path ? ov : 1'b0;
        exp_un   = ok_path ? un : 1'b0;
        exp_acks = !ok_path ? 0 : (compliant ? 2 : ACK_MAX + 1);
        exp_lat  = !ok_path ? TIMEOUT + 3 : (compliant ? lat + 3 : lat + ACK_MAX + 3);

        m_lat           = lat;
        m_compliant     = compliant;
        bus.mult_result = res;
        bus.mult_ov     = ov;
        bus.mult_un     = un;

        chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_op_a  = a;
        bus.in_op_b  = b;
        tick();
        bus.in_valid = 1'b0;
        bus.in_op_a  = $urandom;
        bus.in_op_b  = $urandom;
        chk("beg_after_accept", {31'd0, bus.beg_FSM}, 32'd1);
        chk("flags_cleared", {29'd0, bus.out_ov, bus.out_un, bus.out_timeout}, 32'd0);

        beg_cyc = cyc; beg_cnt = 0; ack_cnt = 0; abort_cnt = 0; t = 0; op_bad = 0;
        while (!bus.out_valid && t < 300) begin
            beg_cnt   += int'(bus.beg_FSM);
            ack_cnt   += int'(bus.rst_FSM);
            abort_cnt += int'(bus.mult_abort);
            if (bus.op_a !== a || bus.op_b !== b) op_bad++;
            tick();
            t++;
        end
        chk("out_valid_reached", {31'd0, bus.out_valid}, 32'd1);
        chk("latency", cyc - beg_cyc, exp_lat);
        chk("beg_pulses", beg_cnt, 1);
        chk("ack_cycles", ack_cnt, exp_acks);
        chk("abort_pulses", abort_cnt, int'(exp_to));
        chk("ops_stable", op_bad, 0);
        chk("out_result", bus.out_result, exp_res);
        chk("out_flags", {29'd0, bus.out_ov, bus.out_un, bus.out_timeout},
            {29'd0, exp_ov, exp_un, exp_to});

        held = bus.out_result;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = $urandom_range(0, 1);
            tick();
            chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("hold_result", bus.out_result, held);
            chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("release_busy", {31'd0, bus.busy}, 32'd0);
        chk("release_no_issue", {31'd0, bus.beg_FSM}, 32'd0);
        chk("release_op_a_kept", bus.op_a, a);
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_op_a     = '0;
        bus.in_op_b     = '0;
        bus.mult_ready  = 1'b0;
        bus.mult_result = '0;
        bus.mult_ov     = 1'b0;
        bus.mult_un     = 1'b0;
        bus.out_ready   = 1'b0;

        tick();
        tick();
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_ctrl", {27'd0, bus.beg_FSM, bus.rst_FSM, bus.mult_abort, bus.out_valid, bus.busy}, 32'd0);
        chk("rst_data", bus.op_a | bus.op_b | bus.out_result, 32'd0);
        chk("rst_flags", {29'd0, bus.out_ov, bus.out_un, bus.out_timeout}, 32'd0);
        rst = 1'b0;
        tick();

        // Ready pulses seen while idle must not start anything.
        bus.mult_ready = 1'b1;
        tick();
        tick();
        chk("idle_ready_ignored", {30'd0, bus.busy, bus.out_valid}, 32'd0);
        bus.mult_ready = 1'b0;
        tick();

        run_op(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 20, 1'b1, 0);
        run_op($urandom, $urandom, $urandom, 1'b0, 1'b1, 5, 1'b1, 10);
        run_op($urandom, $urandom, $urandom, 1'b1, 1'b1, 1000, 1'b1, 1);
        run_op($urandom, $urandom, $urandom, 1'b1, 1'b1, 7, 1'b0, 2);
        run_op($urandom, $urandom, 32'h7F800000, 1'b1, 1'b0, 12, 1'b1, 1);
        run_op($urandom, $urandom, $urandom, 1'b0, 1'b0, 3, 1'b1, 0);
        run_op($urandom, $urandom, $urandom, 1'b1, 1'b0, TIMEOUT + 1, 1'b1, 0);
        run_op($urandom, $urandom, $urandom, 1'b0, 1'b1, TIMEOUT + 2, 1'b1, 0);
        run_op($urandom, $urandom, $urandom, 1'b1, 1'b1, 1, 1'b1, 0);

        for (int k = 0; k < 12; k++) begin
            int lat;
            lat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(65, 90)) : int'($urandom_range(1, 64));
            run_op($urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), lat,
                   $urandom_range(0, 3) != 0, $urandom_range(0, 4));
        end

        // Reset in the fifth WAIT cycle must clear everything immediately.
        m_lat        = 1000;
        m_compliant  = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op_a  = 32'h3F800000;
        bus.in_op_b  = 32'h3F800000;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_wait_busy", {31'd0, bus.busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("async_busy", {31'd0, bus.busy}, 32'd0);
        chk("async_op_a", bus.op_a, 32'd0);
        tick();
        rst            = 1'b0;
        m_pending      = 1'b0;
        bus.mult_ready = 1'b0;
        tick();
        run_op(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 20, 1'b1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fp_mult_requester.md
Name: fp_mult_requester

Overview:
- Initiator side of the floating-point multiplier's begin/ready/acknowledge protocol.
- Accepts operand pairs from an upstream valid/ready stream and registers them onto the multiplier operand bus.
- Pulses begin, waits for the multiplier's ready, then captures the result and exception flags.
- Acknowledges so the multiplier returns to its zero state, and presents the result downstream with valid/ready and a watchdog timeout.

Parameters:
- W, 32, operand/result width (single precision).
- TIMEOUT, 63, max cycles in WAIT before abort (needs 1..255; the 8-bit timer limits it to 255).
- ACK_MAX, 3, max cycles rst_FSM is held waiting for ready to drop.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream operand pair valid
- in_ready  out  1  requester can accept operands
- in_op_a  in  W  operand A
- in_op_b  in  W  operand B
- op_a  out  W  registered operand A to multiplier
- op_b  out  W  registered operand B to multiplier
- beg_FSM  out  1  begin pulse to multiplier
- rst_FSM  out  1  acknowledge to multiplier
- mult_abort  out  1  one-cycle pulse, ORed into multiplier reset on watchdog
- mult_ready  in  1  multiplier result-ready
- mult_result  in  W  multiplier final result
- mult_ov  in  1  multiplier overflow flag
- mult_un  in  1  multiplier underflow flag
- out_valid  out  1  result valid downstream
- out_ready  in  1  downstream accepts result
- out_result  out  W  captured result
- out_ov  out  1  captured overflow
- out_un  out  1  captured underflow
- out_timeout  out  1  result invalid, watchdog fired
- busy  out  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE; op_a=op_b=0; out_result=0; out_ov=out_un=out_timeout=0; timer=0.
- Reset values of outputs: beg_FSM=rst_FSM=mult_abort=out_valid=0; in_ready=1; busy=0.
- All control outputs are Moore, decoded from state. Data registers load on clock edges only.
- States, 3-bit encoding: IDLE=0, ISSUE=1, WAIT=2, ACK=3, HOLD=4, ABORT=5. Unused codes go to IDLE next cycle.
- IDLE:
  - in_ready=1.
  - On in_valid: load op_a/op_b, clear out_ov/out_un/out_timeout, go ISSUE.
  - mult_ready is ignored.
- ISSUE:
  - beg_FSM=1 for exactly one cycle; timer<=0; go WAIT.
  - Operands stay stable from this cycle until HOLD exits.
- WAIT:
  - If mult_ready=1: load out_result<=mult_result, out_ov<=mult_ov, out_un<=mult_un; timer<=0; go ACK.
  - Else if timer==TIMEOUT: go ABORT.
  - Else timer<=timer+1. The timer is 8 bits and saturates; it never wraps.
- ACK:
  - rst_FSM=1.
  - If mult_ready=0: go HOLD.
  - Else if timer==ACK_MAX: go ABORT.
  - Else timer++.
  - With a compliant multiplier, ready drops one cycle after rst_FSM, so ACK lasts 2 cycles.
- ABORT:
  - mult_abort=1 for one cycle; out_result<=0; out_timeout<=1; go HOLD.
  - If abort came from ACK, out_ov/out_un keep their captured values.
- HOLD:
  - out_valid=1; outputs stay stable while out_ready=0.
  - On out_ready=1: go IDLE.
- Latency: in_valid accept → beg_FSM on the next cycle.
  - mult_ready seen at WAIT cycle k → out_valid asserted at k+3 (ACK 2 cycles).
- No accept in HOLD. Back-to-back throughput is limited by one IDLE cycle between operations.
- Simultaneous in_valid with out_ready in HOLD: out_ready is honoured and in_valid is ignored until IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. The multiplier is reset by the same rst.
- mult_ready rising in IDLE, ISSUE or HOLD is ignored; there is no capture.

Test Plan:
- Normal flow:
  - Stimulus: in_op_a=0x40000000, in_op_b=0x40400000; model asserts ready 20 cycles after beg with result 0x40C00000, ov=un=0.
  - Required: beg_FSM exactly one cycle; rst_FSM for 2 cycles; out_valid with out_result=0x40C00000, out_timeout=0.
- Backpressure:
  - Stimulus: out_ready held low 10 cycles in HOLD.
  - Required: out_valid and out_result stable; in_ready=0 throughout; release → IDLE next cycle, in_ready=1.
- WAIT watchdog:
  - Stimulus: mult_ready never asserts.
  - Required: mult_abort pulses exactly TIMEOUT+1=64 cycles after the ISSUE cycle; out_valid with out_result=0, out_timeout=1.
- ACK stuck:
  - Stimulus: mult_ready stays high after rst_FSM.
  - Required: rst_FSM held 4 cycles, then mult_abort; out_timeout=1; out_ov/out_un keep captured values.
- Exception capture:
  - Stimulus: result 0x7F800000 with mult_ov=1.
  - Required: out_ov=1, out_un=0, out_result=0x7F800000.
  - Follow-up: next operation shows the flags cleared on accept.
- Reset mid-WAIT:
  - Stimulus: assert rst at WAIT cycle 5.
  - Required: same-cycle async return to IDLE, in_ready=1, busy=0, op_a=0.
  - Then: a new operation completes normally.
